// File: rtl/mem_march_ctrl.sv
// mem_march_ctrl: four-phase march (W0 P, R0 P, W1 ~P, R1 ~P) over a single-port
// synchronous RAM with registered read data; reports pass, error count and first failure.
module mem_march_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] pattern,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W+1:0] err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              first_err_phase,
   output logic [DATA_W-1:0] first_err_data,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DRAIN, DONE} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] pat_q, pat_d;
   logic              mode_q, mode_d;
   logic              pass_q, pass_d;
   logic [ADDR_W+1:0] err_q, err_d;
   logic [ADDR_W-1:0] fa_q, fa_d;
   logic              fp_q, fp_d;
   logic [DATA_W-1:0] fd_q, fd_d;
   logic              cmp_v_q;
   logic [ADDR_W-1:0] cmp_addr_q;
   logic              cmp_ph_q;
   logic [DATA_W-1:0] cmp_exp_q;
   logic              in_phase, last, accept, inv, mismatch;
   logic [DATA_W-1:0] exp_val;
   always_comb begin
      in_phase = state_q == W0 || state_q == R0 || state_q == W1 || state_q == R1;
      last     = cnt_q == ADDR_W'((1 << ADDR_W) - 1);
      accept   = state_q == IDLE && start;
      inv      = state_q == W1 || state_q == R1;
      exp_val  = (mode_q ? pat_q ^ DATA_W'(cnt_q) : pat_q) ^ {DATA_W{inv}};
      mem_we   = state_q == W0 || state_q == W1;
      mem_re   = state_q == R0 || state_q == R1;
      mem_addr = cnt_q;
      mem_wdata = mem_we ? exp_val : '0;
      busy     = in_phase || state_q == DRAIN;
      done     = state_q == DONE;
      mismatch = cmp_v_q && mem_rdata != cmp_exp_q;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? W0 : IDLE;
         W0:      state_d = last ? R0 : W0;
         R0:      state_d = last ? W1 : R0;
         W1:      state_d = last ? R1 : W1;
         R1:      state_d = last ? DRAIN : R1;
         DRAIN:   state_d = DONE;
         default: state_d = IDLE;
      endcase
      cnt_d  = in_phase ? cnt_q + 1'b1 : '0;
      pat_d  = accept ? pattern : pat_q;
      mode_d = accept ? mode : mode_q;
      err_d  = accept ? '0 : err_q + {{(ADDR_W+1){1'b0}}, mismatch};
      // first-failure capture only while no earlier mismatch exists this run
      fa_d   = accept ? '0 : (mismatch && err_q == '0) ? cmp_addr_q : fa_q;
      fp_d   = accept ? 1'b0 : (mismatch && err_q == '0) ? cmp_ph_q : fp_q;
      fd_d   = accept ? '0 : (mismatch && err_q == '0) ? mem_rdata : fd_q;
      pass_d = accept ? 1'b0 : state_q == DRAIN ? err_d == '0 : pass_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pat_q      <= '0;
         mode_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         fa_q       <= '0;
         fp_q       <= 1'b0;
         fd_q       <= '0;
         cmp_v_q    <= 1'b0;
         cmp_addr_q <= '0;
         cmp_ph_q   <= 1'b0;
         cmp_exp_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pat_q      <= pat_d;
         mode_q     <= mode_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         fa_q       <= fa_d;
         fp_q       <= fp_d;
         fd_q       <= fd_d;
         cmp_v_q    <= mem_re;
         cmp_addr_q <= cnt_q;
         cmp_ph_q   <= state_q == R1;
         cmp_exp_q  <= exp_val;
      end
   end
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign first_err_addr  = fa_q;
   assign first_err_phase = fp_q;
   assign first_err_data  = fd_q;
endmodule

// File: tb/tb_mem_march_ctrl.sv
// tb_mem_march_ctrl: RAM model with injectable faults plus a march reference model.
module tb_mem_march_ctrl;
   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
   logic [7:0] pattern = '0;
   logic       busy, done, pass, first_err_phase, mem_we, mem_re;
   logic [6:0] err_count;
   logic [4:0] first_err_addr, mem_addr;
   logic [7:0] first_err_data, mem_wdata, mem_rdata;
   int tests = 0, fails = 0;
   int fault_kind = 0, f_bit = 0;
   logic [4:0] f_addr = '0;
   logic f_val = 1'b0;
   logic [7:0] ram [32];
   int nbusy, ndone, bus_bad;
   logic [7:0] wd_log [129];
   int e_err;
   logic [4:0] e_fa;
   logic e_fp;
   logic [7:0] e_fd;

   mem_march_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .mode(mode),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .first_err_phase(first_err_phase),
      .first_err_data(first_err_data), .mem_we(mem_we), .mem_re(mem_re),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] fault_rd(input logic [4:0] a, input logic [7:0] v);
      logic [7:0] r;
      r = v;
      if (fault_kind == 1 && a == f_addr) r[f_bit] = f_val;
      if (fault_kind == 2) r = 8'hFF;
      return r;
   endfunction

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= fault_rd(mem_addr, ram[mem_addr]);
   end

   function automatic logic [7:0] exp_of(input logic [7:0] p, input logic m, input int a, input bit upper);
      logic [7:0] b;
      b = m ? p ^ 8'(a) : p;
      return upper ? ~b : b;
   endfunction

   // each read returns the faulted version of what the matching write phase stored
   task automatic model(input logic [7:0] p, input logic m);
      logic [7:0] ev, ob;
      e_err = 0; e_fa = '0; e_fp = 1'b0; e_fd = '0;
      for (int ph = 0; ph < 2; ph++)
         for (int a = 0; a < 32; a++) begin
            ev = exp_of(p, m, a, ph == 1);
            ob = fault_rd(5'(a), ev);
            if (ob != ev) begin
               if (e_err == 0) begin e_fa = 5'(a); e_fp = ph[0]; e_fd = ob; end
               e_err++;
            end
         end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // hold: 0 single pulse, 1 start held high, 2 re-pulse with changed inputs mid-run
   task automatic run_march(input logic [7:0] p, input logic m, input int hold);
      int k, ph, a;
      bit seen, ewe, ere;
      logic [7:0] ewd;
      nbusy = 0; ndone = 0; bus_bad = 0; seen = 0; k = 0;
      start = 1'b0; tick();
      pattern = p; mode = m; start = 1'b1; tick();
      if (hold != 1) start = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         if (hold == 2 && k == 50) begin start = 1'b1; pattern = ~p; mode = ~m; end
         if (hold == 2 && k == 53) start = 1'b0;
         if (busy) begin
            if (k < 129) begin
               ph = k / 32; a = k % 32;
               ewe = k < 128 && ph % 2 == 0;
               ere = k < 128 && ph % 2 == 1;
               ewd = ewe ? exp_of(p, m, a, ph >= 2) : 8'h00;
               if (mem_we !== ewe || mem_re !== ere || mem_wdata !== ewd || (k < 128 && mem_addr !== 5'(a))) bus_bad++;
               wd_log[k] = mem_wdata;
            end
            k++; nbusy++;
         end
         if (done) begin ndone++; seen = 1; end
         else tick();
      end
      if (hold == 2) begin pattern = p; mode = m; end
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      tests++; if ({busy, done, pass, mem_we, mem_re} !== 5'b0) begin fails++; $display("FAIL reset_ctl busy/done/pass/we/re=%b required 00000", {busy, done, pass, mem_we, mem_re}); end
      tests++; if (err_count !== 7'd0 || mem_addr !== 5'd0 || mem_wdata !== 8'd0) begin fails++; $display("FAIL reset_data err=%0d addr=%0d wdata=%h required 0", err_count, mem_addr, mem_wdata); end
      tests++; if (first_err_addr !== 5'd0 || first_err_phase !== 1'b0 || first_err_data !== 8'd0) begin fails++; $display("FAIL reset_first addr=%0d ph=%b data=%h required 0", first_err_addr, first_err_phase, first_err_data); end
   endtask

   task automatic test_ideal();
      fault_kind = 0;
      run_march(8'hA5, 1'b0, 0);
      tests++; if (nbusy != 129) begin fails++; $display("FAIL ideal_busy got %0d required 129", nbusy); end
      tests++; if (ndone != 1 || busy !== 1'b0) begin fails++; $display("FAIL ideal_done pulses=%0d busy=%b required 1,0", ndone, busy); end
      tests++; if (bus_bad != 0) begin fails++; $display("FAIL ideal_bus bad_cycles=%0d required 0", bus_bad); end
      tests++; if (wd_log[0] !== 8'hA5 || wd_log[31] !== 8'hA5 || wd_log[64] !== 8'h5A || wd_log[95] !== 8'h5A) begin fails++; $display("FAIL ideal_wdata got %h %h %h %h required a5 a5 5a 5a", wd_log[0], wd_log[31], wd_log[64], wd_log[95]); end
      tests++; if (pass !== 1'b1 || err_count !== 7'd0) begin fails++; $display("FAIL ideal_result pass=%b err=%0d required 1,0", pass, err_count); end
      tick(); tick();
      tests++; if (done !== 1'b0 || pass !== 1'b1) begin fails++; $display("FAIL ideal_hold done=%b pass=%b required 0,1", done, pass); end
   endtask

   task automatic test_stuck();
      fault_kind = 1; f_addr = 5'd7; f_bit = 0; f_val = 1'b0;
      run_march(8'h01, 1'b0, 0);
      tests++; if (err_count !== 7'd1 || pass !== 1'b0) begin fails++; $display("FAIL stuck_count err=%0d pass=%b required 1,0", err_count, pass); end
      tests++; if (first_err_addr !== 5'd7 || first_err_phase !== 1'b0 || first_err_data !== 8'h00) begin fails++; $display("FAIL stuck_first addr=%0d ph=%b data=%h required 7,0,00", first_err_addr, first_err_phase, first_err_data); end
   endtask

   task automatic test_xor();
      fault_kind = 0;
      run_march(8'hF0, 1'b1, 0);
      tests++; if (wd_log[5] !== 8'hF5 || wd_log[69] !== 8'h0A) begin fails++; $display("FAIL xor_wdata w0=%h w1=%h required f5,0a", wd_log[5], wd_log[69]); end
      tests++; if (bus_bad != 0 || pass !== 1'b1) begin fails++; $display("FAIL xor_run bad=%0d pass=%b required 0,1", bus_bad, pass); end
   endtask

   task automatic test_all_ff();
      fault_kind = 2;
      run_march(8'h00, 1'b0, 0);
      tests++; if (err_count !== 7'd32 || pass !== 1'b0) begin fails++; $display("FAIL allff_count err=%0d pass=%b required 32,0", err_count, pass); end
      tests++; if (first_err_addr !== 5'd0 || first_err_phase !== 1'b0 || first_err_data !== 8'hFF) begin fails++; $display("FAIL allff_first addr=%0d ph=%b data=%h required 0,0,ff", first_err_addr, first_err_phase, first_err_data); end
   endtask

   task automatic test_start_held();
      fault_kind = 0;
      run_march(8'h3C, 1'b1, 2);
      tests++; if (nbusy != 129 || ndone != 1 || bus_bad != 0) begin fails++; $display("FAIL repulse_run busy=%0d done=%0d bad=%0d required 129,1,0", nbusy, ndone, bus_bad); end
      run_march(8'h96, 1'b0, 1);
      tests++; if (nbusy != 129 || ndone != 1 || bus_bad != 0) begin fails++; $display("FAIL held_run busy=%0d done=%0d bad=%0d required 129,1,0", nbusy, ndone, bus_bad); end
      tick();
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL held_idle busy=%b done=%b required 0,0", busy, done); end
      tick();
      tests++; if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd0) begin fails++; $display("FAIL held_restart busy=%b we=%b addr=%0d required 1,1,0", busy, mem_we, mem_addr); end
      start = 1'b0;
   endtask

   task automatic test_rst_midrun();
      fault_kind = 2;
      pattern = 8'h00; mode = 1'b0; start = 1'b1;
      rst = 1'b1; tick(); rst = 1'b0; tick();
      start = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      tests++; if (mem_re !== 1'b1 || err_count == 7'd0) begin fails++; $display("FAIL midrun_r0 re=%b err=%0d required 1,nonzero", mem_re, err_count); end
      rst = 1'b1; tick(); rst = 1'b0;
      tests++; if ({busy, mem_we, mem_re, pass, done} !== 5'b0 || err_count !== 7'd0) begin fails++; $display("FAIL midrun_rst ctl=%b err=%0d required 00000,0", {busy, mem_we, mem_re, pass, done}, err_count); end
      tick();
      tests++; if (err_count !== 7'd0 || mem_re !== 1'b0) begin fails++; $display("FAIL midrun_drop err=%0d re=%b required 0,0", err_count, mem_re); end
      fault_kind = 0;
      run_march(8'h5A, 1'b0, 0);
      tests++; if (nbusy != 129 || pass !== 1'b1 || err_count !== 7'd0) begin fails++; $display("FAIL midrun_rerun busy=%0d pass=%b err=%0d required 129,1,0", nbusy, pass, err_count); end
   endtask

   task automatic test_random();
      logic [7:0] p;
      logic m;
      for (int it = 0; it < 8; it++) begin
         p = 8'($urandom); m = 1'($urandom_range(0, 1));
         fault_kind = $urandom_range(0, 2); f_addr = 5'($urandom); f_bit = $urandom_range(0, 7); f_val = 1'($urandom_range(0, 1));
         model(p, m);
         run_march(p, m, 0);
         tests++; if (nbusy != 129 || ndone != 1 || bus_bad != 0) begin fails++; $display("FAIL rand%0d_run busy=%0d done=%0d bad=%0d required 129,1,0", it, nbusy, ndone, bus_bad); end
         tests++; if (err_count !== 7'(e_err) || pass !== (e_err == 0)) begin fails++; $display("FAIL rand%0d_count err=%0d pass=%b required %0d,%b", it, err_count, pass, e_err, e_err == 0); end
         if (e_err != 0) begin
            tests++; if (first_err_addr !== e_fa || first_err_phase !== e_fp || first_err_data !== e_fd) begin fails++; $display("FAIL rand%0d_first addr=%0d ph=%b data=%h required %0d,%b,%h", it, first_err_addr, first_err_phase, first_err_data, e_fa, e_fp, e_fd); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck();
      test_xor();
      test_all_ff();
      test_start_held();
      test_rst_midrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
